// File: rtl/l2_req_out_queue_pkg.sv
// Shared types and constants for the L2 request-out queue.
//   spandex_consts : coherence message encodings and field widths
//   spandex_types  : request entry struct and the word-granular merge helper
//                    used when back-to-back write-through requests coalesce

package spandex_consts;

  localparam int unsigned COH_MSG_W      = 5;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned LINE_ADDR_W    = 28;

  typedef logic [COH_MSG_W-1:0] coh_msg_t;

  localparam coh_msg_t REQ_S  = 5'd0;
  localparam coh_msg_t REQ_M  = 5'd1;
  localparam coh_msg_t REQ_WT = 5'd2;
  localparam coh_msg_t REQ_O  = 5'd3;
  localparam coh_msg_t REQ_WB = 5'd4;

endpackage

package spandex_types;

  import spandex_consts::*;

  typedef logic [1:0]                         hprot_t;
  typedef logic [LINE_ADDR_W-1:0]             line_addr_t;
  typedef logic [WORDS_PER_LINE*WORD_W-1:0]   line_t;
  typedef logic [WORDS_PER_LINE-1:0]          word_mask_t;

  typedef struct packed {
    coh_msg_t   coh_msg;
    hprot_t     hprot;
    line_addr_t addr;
    line_t      line;
    word_mask_t word_mask;
  } l2_req_out_entry_t;

  // Words selected by mask come from new_line, all others keep old_line.
  function automatic line_t merge_wt_line(input line_t      old_line,
                                          input line_t      new_line,
                                          input word_mask_t mask);
    line_t res;
    res = old_line;
    for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
      if (mask[i]) res[i*WORD_W +: WORD_W] = new_line[i*WORD_W +: WORD_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_req_out_queue.sv
// Elastic FIFO between the L2 req_out channel and the request NoC plane.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   request from L2 (in_ready depends on occupancy only)
//   in_data_*           coh_msg, hprot, addr, line, word_mask of the request
//   out_valid/out_ready head entry toward the NoC
//   out_data_*          registered head entry; holds last head when empty
//   count, empty        occupancy
//
// Build option: define L2_REQ_OUT_COALESCE_EN to merge a write-through
// request into a matching write-through tail entry (same addr and hprot,
// tail not the head) instead of allocating a new entry.

module l2_req_out_queue
  import spandex_consts::*;
  import spandex_types::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  coh_msg_t   in_data_coh_msg,
  input  hprot_t     in_data_hprot,
  input  line_addr_t in_data_addr,
  input  line_t      in_data_line,
  input  word_mask_t in_data_word_mask,
  output logic       out_valid,
  input  logic       out_ready,
  output coh_msg_t   out_data_coh_msg,
  output hprot_t     out_data_hprot,
  output line_addr_t out_data_addr,
  output line_t      out_data_line,
  output word_mask_t out_data_word_mask,
  output logic [PTR_W:0] count,
  output logic       empty
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  l2_req_out_entry_t mem_q [DEPTH];
  l2_req_out_entry_t mem_d [DEPTH];
  l2_req_out_entry_t head_q, head_d;
  l2_req_out_entry_t in_entry;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic push, pop, alloc, coalesce;

  assign in_entry = '{coh_msg:   in_data_coh_msg,
                      hprot:     in_data_hprot,
                      addr:      in_data_addr,
                      line:      in_data_line,
                      word_mask: in_data_word_mask};

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign empty     = (count_q == '0);
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef L2_REQ_OUT_COALESCE_EN
  logic [PTR_W-1:0]  tail_ptr;
  l2_req_out_entry_t tail_entry;

  assign tail_ptr   = wr_ptr_q - PTR_ONE;
  assign tail_entry = mem_q[tail_ptr];
  // count >= 2 keeps the head (possibly being popped right now) untouched.
  assign coalesce = push
                 && (in_data_coh_msg == REQ_WT)
                 && (count_q >= (PTR_W+1)'(2))
                 && (tail_entry.coh_msg == REQ_WT)
                 && (tail_entry.addr == in_data_addr)
                 && (tail_entry.hprot == in_data_hprot);
`else
  assign coalesce = 1'b0;
`endif

  assign alloc = push && !coalesce;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (alloc) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

`ifdef L2_REQ_OUT_COALESCE_EN
    if (coalesce) begin
      mem_d[tail_ptr].line      = merge_wt_line(tail_entry.line, in_data_line,
                                                in_data_word_mask);
      mem_d[tail_ptr].word_mask = tail_entry.word_mask | in_data_word_mask;
    end
`endif

    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({alloc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The output register tracks the post-update head so a fresh push is
    // visible after its edge, including a merge into a tail that just
    // became the head.
    head_d = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign out_data_coh_msg   = head_q.coh_msg;
  assign out_data_hprot     = head_q.hprot;
  assign out_data_addr      = head_q.addr;
  assign out_data_line      = head_q.line;
  assign out_data_word_mask = head_q.word_mask;

  // A stalled request must not change underneath the queue.
  a_in_stable: assert property (@(posedge clk) disable iff (!rst)
    (in_valid && !in_ready) |=> (!in_valid || $stable(in_entry)));

endmodule

// File: tb/tb_l2_req_out_queue.sv
module tb_l2_req_out_queue;

  import spandex_consts::*;
  import spandex_types::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  coh_msg_t   in_data_coh_msg = '0;
  hprot_t     in_data_hprot = '0;
  line_addr_t in_data_addr = '0;
  line_t      in_data_line = '0;
  word_mask_t in_data_word_mask = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  coh_msg_t   out_data_coh_msg;
  hprot_t     out_data_hprot;
  line_addr_t out_data_addr;
  line_t      out_data_line;
  word_mask_t out_data_word_mask;
  logic [2:0] count;
  logic       empty;

  int total = 0;
  int bad   = 0;

  l2_req_out_entry_t sb[$];

  always #5 clk = ~clk;

  l2_req_out_queue #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data_coh_msg    (in_data_coh_msg),
    .in_data_hprot      (in_data_hprot),
    .in_data_addr       (in_data_addr),
    .in_data_line       (in_data_line),
    .in_data_word_mask  (in_data_word_mask),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data_coh_msg   (out_data_coh_msg),
    .out_data_hprot     (out_data_hprot),
    .out_data_addr      (out_data_addr),
    .out_data_line      (out_data_line),
    .out_data_word_mask (out_data_word_mask),
    .count              (count),
    .empty              (empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input coh_msg_t m, input hprot_t hp,
                       input line_addr_t a, input line_t l, input word_mask_t wm);
    in_valid          = v;
    in_data_coh_msg   = m;
    in_data_hprot     = hp;
    in_data_addr      = a;
    in_data_line      = l;
    in_data_word_mask = wm;
  endtask

  // Scoreboard: decides acceptance from its own occupancy model just before
  // each rising edge, checks handshake flags, and compares popped heads.
  always @(negedge clk) begin : monitor
    int sz;
    logic exp_push, exp_pop, merge;
    l2_req_out_entry_t got, in_cur, tmp;
    if (rst) begin
      sz       = sb.size();
      exp_push = in_valid && (sz < DEPTH);
      exp_pop  = out_ready && (sz != 0);
      in_cur   = '{coh_msg: in_data_coh_msg, hprot: in_data_hprot, addr: in_data_addr,
                   line: in_data_line, word_mask: in_data_word_mask};

      total++;
      if (in_ready !== (sz < DEPTH)) begin
        bad++; $display("FAIL mon_in_ready: got %0b expected %0b", in_ready, sz < DEPTH);
      end
      total++;
      if (out_valid !== (sz != 0)) begin
        bad++; $display("FAIL mon_out_valid: got %0b expected %0b", out_valid, sz != 0);
      end
      total++;
      if (count !== 3'(sz)) begin
        bad++; $display("FAIL mon_count: got %0d expected %0d", count, sz);
      end
      total++;
      if (empty !== (sz == 0)) begin
        bad++; $display("FAIL mon_empty: got %0b expected %0b", empty, sz == 0);
      end

      if (exp_pop) begin
        got = '{coh_msg: out_data_coh_msg, hprot: out_data_hprot, addr: out_data_addr,
                line: out_data_line, word_mask: out_data_word_mask};
        total++;
        if (got !== sb[0]) begin
          bad++;
          $display("FAIL mon_pop_data: got addr=%0h msg=%0d mask=%b line=%h expected addr=%0h msg=%0d mask=%b line=%h",
                   got.addr, got.coh_msg, got.word_mask, got.line,
                   sb[0].addr, sb[0].coh_msg, sb[0].word_mask, sb[0].line);
        end
      end

      merge = 1'b0;
`ifdef L2_REQ_OUT_COALESCE_EN
      if (exp_push && in_cur.coh_msg == REQ_WT && sz >= 2) begin
        tmp = sb[sz-1];
        merge = (tmp.coh_msg == REQ_WT) && (tmp.addr == in_cur.addr) && (tmp.hprot == in_cur.hprot);
        if (merge) begin
          for (int w = 0; w < 4; w++)
            if (in_cur.word_mask[w]) tmp.line[w*32 +: 32] = in_cur.line[w*32 +: 32];
          tmp.word_mask = tmp.word_mask | in_cur.word_mask;
          sb[sz-1] = tmp;
        end
      end
`endif
      if (exp_pop) void'(sb.pop_front());
      if (exp_push && !merge) sb.push_back(in_cur);
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d expected 0", count); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %0b expected 1", empty); end
    rst = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, REQ_S, 2'd0, line_addr_t'(28'h1 + i), line_t'(128'h5555 + i), 4'hF);
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL rst_pre_count: got %0d expected 3", count); end
    rst = 1'b0;
    sb.delete();
    #1;
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL rst_async_count: got %0d expected 0", count); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %0b expected 0", out_valid); end
    total++;
    if (out_data_addr !== 28'h0) begin bad++; $display("FAIL rst_async_addr: got %0h expected 0", out_data_addr); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    drive(1'b1, REQ_S, 2'd1, 28'h100, 128'hDEAD_BEEF, 4'b0011);
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0b expected 1", out_valid); end
    total++;
    if (out_data_addr !== 28'h100) begin bad++; $display("FAIL basic_addr: got %0h expected 100", out_data_addr); end
    total++;
    if (count !== 3'd1) begin bad++; $display("FAIL basic_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty: got %0b expected 1", empty); end
    total++;
    if (out_data_addr !== 28'h100) begin bad++; $display("FAIL basic_hold_addr: got %0h expected 100", out_data_addr); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, REQ_M, 2'd0, line_addr_t'(28'h10 + i), line_t'(128'hA000 + i), 4'hF);
      tick();
    end
    drive(1'b1, REQ_M, 2'd0, 28'h14, 128'hA004, 4'hF);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d expected 4", count); end
    total++;
    if (out_data_addr !== 28'h10) begin bad++; $display("FAIL full_head: got %0h expected 10", out_data_addr); end
    tick(); tick();
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL full_hold_count: got %0d expected 4", count); end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL full_pop_no_push: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, REQ_S, 2'd2, line_addr_t'(28'h200 + i), line_t'(128'hC000 + i), 4'hF);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i % 2 == 0) ? REQ_S : REQ_WT, hprot_t'(i), line_addr_t'(28'h202 + i),
            {$urandom, $urandom, $urandom, $urandom}, word_mask_t'($urandom));
      tick();
      total++;
      if (count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
    end
    in_valid = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_coalesce();
    logic [2:0] exp_cnt;
    word_mask_t exp_mask;
    line_t      exp_line;
`ifdef L2_REQ_OUT_COALESCE_EN
    exp_cnt  = 3'd2;
    exp_mask = 4'b0101;
    exp_line = 128'hA3A3A3A3_B2B2B2B2_A1A1A1A1_A0A0A0A0;
`else
    exp_cnt  = 3'd3;
    exp_mask = 4'b0001;
    exp_line = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
`endif
    out_ready = 1'b0;
    drive(1'b1, REQ_S, 2'd1, 28'h30, 128'h0, 4'hF); tick();
    drive(1'b1, REQ_WT, 2'd1, 28'h40, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 4'b0001); tick();
    drive(1'b1, REQ_WT, 2'd1, 28'h40, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 4'b0100); tick();
    in_valid = 1'b0;
    total++;
    if (count !== exp_cnt) begin bad++; $display("FAIL coal_count: got %0d expected %0d", count, exp_cnt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_data_word_mask !== exp_mask) begin bad++; $display("FAIL coal_mask: got %b expected %b", out_data_word_mask, exp_mask); end
    total++;
    if (out_data_line !== exp_line) begin bad++; $display("FAIL coal_line: got %h expected %h", out_data_line, exp_line); end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    // merge into the tail while the head pops in the same cycle
    drive(1'b1, REQ_S, 2'd0, 28'h50, 128'h0, 4'hF); tick();
    drive(1'b1, REQ_WT, 2'd0, 28'h60, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 4'b0010); tick();
    out_ready = 1'b1;
    drive(1'b1, REQ_WT, 2'd0, 28'h60, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 4'b1000); tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
`ifdef L2_REQ_OUT_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    total++;
    if (count !== exp_cnt) begin bad++; $display("FAIL coal_pop_count: got %0d expected %0d", count, exp_cnt); end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL coal_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_no_merge();
    out_ready = 1'b0;
    drive(1'b1, REQ_WT, 2'd1, 28'h40, 128'h1, 4'b0001); tick();
    drive(1'b1, REQ_WT, 2'd1, 28'h40, 128'h20, 4'b0010); tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd2) begin bad++; $display("FAIL nomerge_head_count: got %0d expected 2", count); end
    drive(1'b1, REQ_WT, 2'd2, 28'h40, 128'h300, 4'b0100); tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL nomerge_hprot_count: got %0d expected 3", count); end
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL nomerge_empty: got %0b expected 1", empty); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_coalesce();
    test_no_merge();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
